operand2_shift_pipe: RTL
========================

// Module: operand2_shift_pipe
// PURPOSE
// - Parametrised, pipelined successor to the combinational operand-2 shifter.
// - Produces the ARM operand-2 value and shifter carry-out for four sources: branch offset, rotated immediate, Rm shifted by an immediate amount, and Rm shifted by Rs[7:0].
// - Sits between register-read and the ALU. Two-stage valid/ready pipeline, full throughput, backpressure from the ALU.
// - Fixes the previous gaps: RRX, #32 encodings, register-specified shifts, carry-out, and arbitrary rotate amounts.
// PARAMETERS
// - DATA_W    32  datapath width; power of 2, 8..128
// - BR_OFF_W  24  branch offset field width; must be < DATA_W-2
// PORTS
// - clk           in   1         clock; all state on rising edge
// - reset_n       in   1         asynchronous active-low reset
// - in_valid      in   1         request present
// - in_ready      out  1         request accepted when in_valid && in_ready
// - mode          in   2         0 BRANCH, 1 IMM_ROT, 2 REG_IMMSH, 3 REG_REGSH
// - data12In      in   12        operand-2 field ([11:8] rot, [7:0] imm8 | [11:7] shamt, [6:5] type)
// - branchOffset  in   BR_OFF_W  signed word offset
// - rmData        in   DATA_W    Rm value
// - rsData        in   8         Rs[7:0], shift amount for REG_REGSH
// - carry_in      in   1         current CPSR C
// - out_valid     out  1         result present
// - out_ready     in   1         ALU consumes when out_valid && out_ready
// - shiftedData   out  DATA_W    operand-2 result
// - carry_out     out  1         shifter carry
// BEHAVIOUR
// - Reset (async, reset_n=0): s1_valid, s2_valid, out_valid = 0; shiftedData = 0; carry_out = 0.
//   Reset mid-operation drops all in-flight items; nothing is replayed.
// - Pipeline:
//   - S1 registers the decoded type, amount (9b), operand, carry_in and mode.
//   - S2 registers the result from shift_core.
//   - Latency: accept in cycle N -> out_valid in N+2. Throughput 1 per cycle.
//   - s2_adv = !s2_valid || out_ready; in_ready = !s1_valid || s2_adv. in_ready is combinational from out_ready, with no other path.
//   - While out_valid && !out_ready: shiftedData and carry_out hold stable and S1 holds.
//   - Simultaneous accept into S1 and drain from S2 in the same cycle is legal and loses nothing.
// - BRANCH: result = sign_extend(branchOffset) << 2 to DATA_W; carry_out = carry_in.
// - IMM_ROT: result = zext(imm8) ROR (2*rot), rotation taken mod DATA_W.
//   carry_out = carry_in if rot == 0, else result[DATA_W-1].
// - REG_IMMSH, with n = shamt:
//   - LSL: n = 0 -> Rm, carry_in; else Rm<<n, carry Rm[DATA_W-n].
//   - LSR: n = 0 means #32 (result 0, carry Rm[MSB]); else Rm>>n, carry Rm[n-1].
//   - ASR: n = 0 means #32 (result all Rm[MSB], carry Rm[MSB]); else arithmetic shift, carry Rm[n-1].
//   - ROR: n = 0 means RRX, result {carry_in, Rm[MSB:1]}, carry Rm[0]; else rotate, carry result[MSB].
//   - For DATA_W != 32, "#32" means DATA_W.
// - REG_REGSH, with n = rsData, W = DATA_W:
//   - n == 0 for any type: result Rm, carry carry_in.
//   - LSL: n < W normal; n == W -> 0, carry Rm[0]; n > W -> 0, carry 0.
//   - LSR: n < W normal; n == W -> 0, carry Rm[MSB]; n > W -> 0, carry 0.
//   - ASR: n >= W -> all sign bits, carry Rm[MSB].
//   - ROR: n mod W == 0 (with n != 0) -> Rm, carry Rm[MSB]; else rotate by n mod W, carry result[MSB].
// - No X is ever driven on any output, in any mode.
// STRUCTURE
// - Package operand2_pkg holds:
//   - mode constants MODE_BRANCH/MODE_IMM_ROT/MODE_REG_IMMSH/MODE_REG_REGSH
//   - shift-type constants SH_LSL/SH_LSR/SH_ASR/SH_ROR
//   - function clog2
// - Decode (#32/RRX/amount normalisation) is done in S1 in this module.
// - Sub-module shift_core: combinational (type, 9b amount, rrx flag, operand, cin) -> (result, cout), parametrised by DATA_W. It is instanced once, feeding S2.
// TESTING
// - Reset: hold reset_n=0 mid-stream with in_valid=1 -> out_valid=0, shiftedData=0; after release, first result appears 2 cycles after first accept.
// - BRANCH: branchOffset=24'hFFFFFF -> 32'hFFFFFFFC, carry=carry_in; 24'h000001 -> 32'h00000004.
// - IMM_ROT: data12In=12'h4FF -> 32'hFF000000, carry=1; 12'h0AB with cin=1 -> 32'h000000AB, carry 1.
// - REG_IMMSH: Rm=32'h80000001:
//   - LSR #0 -> 0, carry 1
//   - ASR #0 -> 32'hFFFFFFFF, carry 1
//   - ROR #0 (cin=0) -> 32'h40000000, carry 1
// - REG_REGSH: Rm=32'h80000001, rs=32 LSL -> 0, carry 1; rs=33 LSR -> 0, carry 0; rs=64 ROR -> Rm, carry 1; rs=0 -> Rm, carry_in.
// - Backpressure: stream 8 back-to-back ops with out_ready toggling randomly -> results in order, none lost or duplicated, outputs stable while stalled, 1 per cycle when out_ready=1.

Source files
------------

// File: rtl/operand2_shift_pipe_pkg.sv
// Shared constants for the operand-2 shifter pipeline: source modes, shift types
// and a width helper.
package operand2_pkg;

  localparam logic [1:0] MODE_BRANCH    = 2'd0;
  localparam logic [1:0] MODE_IMM_ROT   = 2'd1;
  localparam logic [1:0] MODE_REG_IMMSH = 2'd2;
  localparam logic [1:0] MODE_REG_REGSH = 2'd3;

  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/operand2_shift_pipe_shift_core.sv
// Combinational barrel shifter with register-shift semantics (amount 0 passes Rm and cin,
// amounts at or beyond DATA_W saturate) plus an RRX override.
module shift_core
  import operand2_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        sh_type_i,
  input  logic [8:0]        amt_i,
  input  logic              rrx_i,
  input  logic [DATA_W-1:0] opd_i,
  input  logic              cin_i,
  output logic [DATA_W-1:0] result_o,
  output logic              cout_o
);

  localparam int LW = clog2(DATA_W);

  logic [DATA_W:0]   lsl_w;
  logic [DATA_W:0]   lsr_w;
  logic [DATA_W:0]   asr_w;
  logic [DATA_W-1:0] ror_w;
  logic [LW-1:0]     ror_amt;

  // One guard bit beside the operand catches the last bit shifted out; shifting
  // past the guard naturally yields the saturated 0 / sign results.
  assign lsl_w   = {1'b0, opd_i} << amt_i;
  assign lsr_w   = {opd_i, 1'b0} >> amt_i;
  assign asr_w   = $signed({opd_i, 1'b0}) >>> amt_i;
  assign ror_amt = amt_i[LW-1:0];
  assign ror_w   = (opd_i >> ror_amt) | (opd_i << (DATA_W - int'(ror_amt)));

  always_comb begin
    result_o = opd_i;
    cout_o   = cin_i;
    if (rrx_i) begin
      result_o = {cin_i, opd_i[DATA_W-1:1]};
      cout_o   = opd_i[0];
    end else if (amt_i != 9'd0) begin
      case (sh_type_i)
        SH_LSL: begin
          result_o = lsl_w[DATA_W-1:0];
          cout_o   = lsl_w[DATA_W];
        end
        SH_LSR: begin
          result_o = lsr_w[DATA_W:1];
          cout_o   = lsr_w[0];
        end
        SH_ASR: begin
          result_o = asr_w[DATA_W:1];
          cout_o   = asr_w[0];
        end
        default: begin
          result_o = ror_w;
          cout_o   = ror_w[DATA_W-1];
        end
      endcase
    end
  end

endmodule

// File: rtl/operand2_shift_pipe.sv
// Two-stage operand-2 shifter: S1 decodes the source into (type, amount, operand), S2 holds
// the shift_core result. Latency 2, one result per cycle; a stalled ALU freezes S2 then S1.
module operand2_shift_pipe
  import operand2_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int BR_OFF_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          mode,
  input  logic [11:0]         data12In,
  input  logic [BR_OFF_W-1:0] branchOffset,
  input  logic [DATA_W-1:0]   rmData,
  input  logic [7:0]          rsData,
  input  logic                carry_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   shiftedData,
  output logic                carry_out
);

  localparam logic [8:0] AMT_FULL = 9'(DATA_W);

  logic              s1_valid_q;
  logic [1:0]        s1_mode_q;
  logic [1:0]        s1_type_q, s1_type_d;
  logic [8:0]        s1_amt_q, s1_amt_d;
  logic              s1_rrx_q, s1_rrx_d;
  logic [DATA_W-1:0] s1_opd_q, s1_opd_d;
  logic              s1_cin_q;

  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_res_q;
  logic              s2_cout_q;

  logic              s2_adv;
  logic [DATA_W-1:0] core_res;
  logic              core_cout;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;

  // Every source is folded onto the register-shift semantics of shift_core;
  // immediate-shift amount 0 is re-encoded as #DATA_W or RRX here.
  always_comb begin
    s1_type_d = data12In[6:5];
    s1_amt_d  = 9'd0;
    s1_rrx_d  = 1'b0;
    s1_opd_d  = rmData;
    case (mode)
      MODE_BRANCH: begin
        s1_opd_d  = DATA_W'($signed(branchOffset));
        s1_type_d = SH_LSL;
        s1_amt_d  = 9'd2;
      end
      MODE_IMM_ROT: begin
        s1_opd_d  = DATA_W'(data12In[7:0]);
        s1_type_d = SH_ROR;
        s1_amt_d  = {4'd0, data12In[11:8], 1'b0};
      end
      MODE_REG_IMMSH: begin
        s1_amt_d = {4'd0, data12In[11:7]};
        if (data12In[11:7] == 5'd0) begin
          case (data12In[6:5])
            SH_LSR, SH_ASR: s1_amt_d = AMT_FULL;
            SH_ROR:         s1_rrx_d = 1'b1;
            default:        s1_amt_d = 9'd0;
          endcase
        end
      end
      default: s1_amt_d = {1'b0, rsData};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= MODE_BRANCH;
      s1_type_q  <= SH_LSL;
      s1_amt_q   <= 9'd0;
      s1_rrx_q   <= 1'b0;
      s1_opd_q   <= '0;
      s1_cin_q   <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_mode_q <= mode;
        s1_type_q <= s1_type_d;
        s1_amt_q  <= s1_amt_d;
        s1_rrx_q  <= s1_rrx_d;
        s1_opd_q  <= s1_opd_d;
        s1_cin_q  <= carry_in;
      end
    end
  end

  shift_core #(.DATA_W(DATA_W)) u_shift_core (
    .sh_type_i (s1_type_q),
    .amt_i     (s1_amt_q),
    .rrx_i     (s1_rrx_q),
    .opd_i     (s1_opd_q),
    .cin_i     (s1_cin_q),
    .result_o  (core_res),
    .cout_o    (core_cout)
  );

  // Branch offsets pass the CPSR carry through untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_cout_q  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_res_q  <= core_res;
        s2_cout_q <= (s1_mode_q == MODE_BRANCH) ? s1_cin_q : core_cout;
      end
    end
  end

  assign out_valid   = s2_valid_q;
  assign shiftedData = s2_res_q;
  assign carry_out   = s2_cout_q;

endmodule
